// File: rtl/voice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voice_pkg
// Description : Shared types for the voice-command session path. Holds the
//               command encoding used by the session controller and the
//               downstream display/motion consumers, and the controller's
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package voice_pkg;

    // Command encoding shared with the state_controller consumers.
    typedef enum logic [2:0] {
        CMD_WELCOME   = 3'd0,
        CMD_RECORDING = 3'd1,
        CMD_UP        = 3'd2,
        CMD_DOWN      = 3'd3,
        CMD_LEFT      = 3'd4,
        CMD_RIGHT     = 3'd5,
        CMD_STOP      = 3'd6,
        CMD_SILENCE   = 3'd7
    } cmd_t;

    // Session controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_INFER   = 2'd2,
        ST_HOLD    = 2'd3
    } ctrl_state_t;

    localparam int SAMPLE_RATE_HZ = 16000;

    // WELCOME and RECORDING are UI states, never valid inference results,
    // so the ARM reporting either of them is treated as "nothing heard".
    function automatic cmd_t map_arm_cmd(input logic [2:0] raw);
        cmd_t w_cmd;
        if (raw <= 3'd1) begin
            w_cmd = CMD_SILENCE;
        end else begin
            w_cmd = cmd_t'(raw);
        end
        return w_cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Level debouncer. dout follows din only after din has differed
//               from dout for CYCLES consecutive clk samples. Resets to the
//               released (high) level.
// Ports       : clk  - system clock
//               rstb - asynchronous active-low reset
//               din  - synchronised raw level
//               dout - debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rstb,
    input  logic din,
    output logic dout
);

    localparam int                 c_CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dout;

    // Any sample equal to the current output restarts the stability count.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt  <= '0;
            r_dout <= 1'b1;
        end else if (din == r_dout) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_dout <= din;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/rec_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rec_session_ctrl
// Description : Sequences one voice-command session: KEY0 press -> capture a
//               window of SAMPLES_PER_WINDOW samples -> request inference
//               from the ARM under a TIMEOUT_CYCLES watchdog -> latch the
//               resulting command for the display/motion logic.
//               Build option REC_SESSION_DEBOUNCE_EN inserts key_debounce
//               (DEBOUNCE_CYCLES) between the key synchroniser and the
//               press edge detector.
// Ports       : clk, rstb (async, active-low)
//               key_n       - raw KEY0, asynchronous, 0 = pressed
//               sample_stb  - one pulse per accepted audio sample
//               arm_done    - ARM result valid pulse; arm_cmd - ARM result
//               rec_active  - high in CAPTURE; infer_req - high in INFER
//               cmd_out     - last latched command (cmd_t)
//               cmd_valid   - pulse when cmd_out updates
//               timeout_err - pulse when INFER times out
//               state_out   - current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module rec_session_ctrl
    import voice_pkg::*;
#(
    parameter int SAMPLES_PER_WINDOW = 16000,
    parameter int TIMEOUT_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES    = 1_000_000
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       key_n,
    input  logic       sample_stb,
    input  logic       arm_done,
    input  logic [2:0] arm_cmd,
    output logic       rec_active,
    output logic       infer_req,
    output logic [2:0] cmd_out,
    output logic       cmd_valid,
    output logic       timeout_err,
    output logic [1:0] state_out
);

    localparam int                  c_SAMP_W    = $clog2(SAMPLES_PER_WINDOW);
    localparam int                  c_TO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(SAMPLES_PER_WINDOW - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

    generate
        if (SAMPLES_PER_WINDOW < 2 || TIMEOUT_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
            $error("rec_session_ctrl: parameter below its minimum");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Key conditioning: 2-flop synchroniser, optional debounce, and a
    // registered falling-edge detector producing a one-cycle press.
    // ------------------------------------------------------------------
    logic r_key_sync1;
    logic r_key_sync2;
    logic w_key_cond;
    logic r_key_prev;
    logic r_press;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_key_sync1 <= 1'b1;
            r_key_sync2 <= 1'b1;
        end else begin
            r_key_sync1 <= key_n;
            r_key_sync2 <= r_key_sync1;
        end
    end

`ifdef REC_SESSION_DEBOUNCE_EN
    key_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk  (clk),
        .rstb (rstb),
        .din  (r_key_sync2),
        .dout (w_key_cond)
    );
`else
    assign w_key_cond = r_key_sync2;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_key_prev <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            r_key_prev <= w_key_cond;
            r_press    <= r_key_prev & ~w_key_cond;
        end
    end

    // ------------------------------------------------------------------
    // Session FSM
    // ------------------------------------------------------------------
    ctrl_state_t         r_state;
    ctrl_state_t         w_next_state;
    logic [c_SAMP_W-1:0] r_sample_cnt;
    logic [c_TO_W-1:0]   r_timeout_cnt;
    cmd_t                r_cmd;
    logic                r_cmd_valid;
    logic                r_timeout_err;
    logic                w_samp_last;
    logic                w_to_last;

    assign w_samp_last = (r_sample_cnt == c_SAMP_LAST);
    assign w_to_last   = (r_timeout_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (r_press) w_next_state = ST_CAPTURE;
            ST_CAPTURE: if (sample_stb && w_samp_last) w_next_state = ST_INFER;
            ST_INFER:   if (arm_done || w_to_last) w_next_state = ST_HOLD;
            ST_HOLD:    if (r_press) w_next_state = ST_CAPTURE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rec_active = (r_state == ST_CAPTURE);
        infer_req  = (r_state == ST_INFER);
        state_out  = r_state;
    end

    // Counters and command latch. Each counter is cleared on entry to the
    // state that uses it and stops at its terminal value, so it never wraps.
    // arm_done is tested before the timeout so a collision reports the
    // ARM result without an error.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sample_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_cmd         <= CMD_WELCOME;
            r_cmd_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (r_press) r_sample_cnt <= '0;
                end
                ST_CAPTURE: begin
                    if (sample_stb) begin
                        if (w_samp_last) begin
                            r_timeout_cnt <= '0;
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end
                end
                ST_INFER: begin
                    if (arm_done) begin
                        r_cmd       <= map_arm_cmd(arm_cmd);
                        r_cmd_valid <= 1'b1;
                    end else if (w_to_last) begin
                        r_cmd         <= CMD_SILENCE;
                        r_cmd_valid   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_out     = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rec_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rec_session_ctrl
// Description : Self-checking bench for rec_session_ctrl with
//               SAMPLES_PER_WINDOW=4, TIMEOUT_CYCLES=10, DEBOUNCE_CYCLES=3.
//               Table-driven happy path plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rec_session_ctrl;

    localparam int c_SPW = 4;
    localparam int c_TO  = 10;
    localparam int c_DB  = 3;
`ifdef REC_SESSION_DEBOUNCE_EN
    localparam int c_PRESS_LAT = 4 + c_DB;
`else
    localparam int c_PRESS_LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rstb;
    logic       key_n;
    logic       sample_stb;
    logic       arm_done;
    logic [2:0] arm_cmd;
    logic       rec_active;
    logic       infer_req;
    logic [2:0] cmd_out;
    logic       cmd_valid;
    logic       timeout_err;
    logic [1:0] state_out;

    int n_vec = 0;
    int n_bad = 0;

    rec_session_ctrl #(
        .SAMPLES_PER_WINDOW (c_SPW),
        .TIMEOUT_CYCLES     (c_TO),
        .DEBOUNCE_CYCLES    (c_DB)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .key_n       (key_n),
        .sample_stb  (sample_stb),
        .arm_done    (arm_done),
        .arm_cmd     (arm_cmd),
        .rec_active  (rec_active),
        .infer_req   (infer_req),
        .cmd_out     (cmd_out),
        .cmd_valid   (cmd_valid),
        .timeout_err (timeout_err),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic       done;
        logic [2:0] acmd;
        logic [1:0] es;
        logic [2:0] ec;
        logic       ev;
        logic       et;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic stb, input logic done, input logic [2:0] acmd,
                                input logic [1:0] es, input logic [2:0] ec,
                                input logic ev, input logic et);
        vec_t v;
        v.stb = stb; v.done = done; v.acmd = acmd;
        v.es = es; v.ec = ec; v.ev = ev; v.et = et;
        return v;
    endfunction

    task automatic check(input string nm, input logic [1:0] es, input logic [2:0] ec,
                         input logic ev, input logic et);
        logic er;
        logic ei;
        er = (es == 2'd1);
        ei = (es == 2'd2);
        n_vec++;
        if (state_out !== es || rec_active !== er || infer_req !== ei ||
            cmd_out !== ec || cmd_valid !== ev || timeout_err !== et) begin
            n_bad++;
            $display("FAIL %s: got st=%0d rec=%b inf=%b cmd=%0d v=%b to=%b, want st=%0d rec=%b inf=%b cmd=%0d v=%b to=%b",
                     nm, state_out, rec_active, infer_req, cmd_out, cmd_valid, timeout_err,
                     es, er, ei, ec, ev, et);
        end
    endtask

    // One clock with the given pulse inputs; outputs are read 1 ns after the edge.
    task automatic cyc(input logic stb, input logic done, input logic [2:0] acmd);
        sample_stb = stb;
        arm_done   = done;
        arm_cmd    = acmd;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        arm_done   = 1'b0;
        arm_cmd    = 3'd0;
    endtask

    // Hold the key down until CAPTURE is reached (bounded) and check latency.
    task automatic do_press(input string nm);
        int  n;
        bit  got;
        key_n = 1'b1;
        repeat (8) cyc(1'b0, 1'b0, 3'd0);
        key_n = 1'b0;
        got = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            if (state_out == 2'd1) begin
                n = i;
                got = 1'b1;
                break;
            end
        end
        key_n = 1'b1;
        n_vec++;
        if (!got || n != c_PRESS_LAT) begin
            n_bad++;
            $display("FAIL %s: press latency got %0d cycles (reached=%0b), want %0d",
                     nm, n, got, c_PRESS_LAT);
        end
    endtask

    task automatic fill_window(input string nm, input logic [2:0] ec);
        for (int i = 0; i < c_SPW - 1; i++) begin
            cyc(1'b1, 1'b0, 3'd0);
            check(nm, 2'd1, ec, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 3'd0);
        check(nm, 2'd2, ec, 1'b0, 1'b0);
    endtask

    initial begin
        rstb       = 1'b0;
        key_n      = 1'b1;
        sample_stb = 1'b0;
        arm_done   = 1'b0;
        arm_cmd    = 3'd0;

        // Happy path table, entered from the first CAPTURE cycle.
        tbl[0] = mk(1, 0, 3'd0, 2'd1, 3'd0, 0, 0);
        tbl[1] = mk(0, 0, 3'd0, 2'd1, 3'd0, 0, 0);
        tbl[2] = mk(1, 1, 3'd6, 2'd1, 3'd0, 0, 0);  // arm_done in CAPTURE ignored
        tbl[3] = mk(1, 0, 3'd0, 2'd1, 3'd0, 0, 0);
        tbl[4] = mk(1, 0, 3'd0, 2'd2, 3'd0, 0, 0);  // 4th sample -> INFER
        tbl[5] = mk(1, 0, 3'd0, 2'd2, 3'd0, 0, 0);  // sample in INFER ignored
        tbl[6] = mk(0, 1, 3'd3, 2'd3, 3'd3, 1, 0);  // result DOWN
        tbl[7] = mk(0, 0, 3'd0, 2'd3, 3'd3, 0, 0);
        tbl[8] = mk(0, 1, 3'd5, 2'd3, 3'd3, 0, 0);  // arm_done in HOLD ignored
        tbl[9] = mk(1, 0, 3'd0, 2'd3, 3'd3, 0, 0);  // sample in HOLD ignored

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", 2'd0, 3'd0, 1'b0, 1'b0);
        rstb = 1'b1;

        // Events in IDLE are ignored.
        cyc(1'b0, 1'b1, 3'd4);
        check("idle_arm_done", 2'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0);
        check("idle_sample", 2'd0, 3'd0, 1'b0, 1'b0);

        do_press("happy_press");
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].stb, tbl[i].done, tbl[i].acmd);
            check($sformatf("happy_%0d", i), tbl[i].es, tbl[i].ec, tbl[i].ev, tbl[i].et);
        end

        // Presses during CAPTURE and INFER are ignored; arm_cmd=1 -> SILENCE.
        do_press("ign_press");
        key_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("ign_cap_low", 2'd1, 3'd3, 1'b0, 1'b0);
        end
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("ign_cap_high", 2'd1, 3'd3, 1'b0, 1'b0);
        end
        fill_window("ign_fill", 3'd3);
        key_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("ign_inf_low", 2'd2, 3'd3, 1'b0, 1'b0);
        end
        key_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("ign_inf_high", 2'd2, 3'd3, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 3'd1);
        check("ign_cmd1_silence", 2'd3, 3'd7, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 3'd0);
        check("ign_hold", 2'd3, 3'd7, 1'b0, 1'b0);

        // Timeout: 10 INFER cycles without arm_done.
        do_press("to_press");
        fill_window("to_fill", 3'd7);
        for (int i = 0; i < c_TO - 1; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("to_wait", 2'd2, 3'd7, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 3'd0);
        check("to_fire", 2'd3, 3'd7, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 3'd0);
        check("to_after", 2'd3, 3'd7, 1'b0, 1'b0);

        // Collision: arm_done on the 10th INFER cycle wins over the timeout.
        do_press("col_press");
        fill_window("col_fill", 3'd7);
        for (int i = 0; i < c_TO - 1; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("col_wait", 2'd2, 3'd7, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 3'd5);
        check("col_fire", 2'd3, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 3'd0);
        check("col_after", 2'd3, 3'd5, 1'b0, 1'b0);

        // Reset mid-CAPTURE after 2 samples.
        do_press("rst_press");
        cyc(1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 3'd0);
        check("rst_pre", 2'd1, 3'd5, 1'b0, 1'b0);
        rstb = 1'b0;
        #1;
        check("rst_async", 2'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 2'd0, 3'd0, 1'b0, 1'b0);
        rstb = 1'b1;

`ifdef REC_SESSION_DEBOUNCE_EN
        // 2-cycle glitch is filtered; a 5-cycle low gives one press.
        key_n = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 3'd0);
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("db_glitch", 2'd0, 3'd0, 1'b0, 1'b0);
        end
        key_n = 1'b0;
        repeat (5) cyc(1'b0, 1'b0, 3'd0);
        key_n = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (state_out == 2'd1) begin
                    got = 1'b1;
                    break;
                end
                cyc(1'b0, 1'b0, 3'd0);
            end
            n_vec++;
            if (!got) begin
                n_bad++;
                $display("FAIL db_press: got state %0d after 5-cycle low, want 1", state_out);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 3'd0);
            check("db_stay", 2'd1, 3'd0, 1'b0, 1'b0);
        end
`else
        do_press("rst_repress");
`endif
        // Fresh window: 3 samples stay in CAPTURE, the 4th enters INFER.
        fill_window("rst_fill", 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rec_session_ctrl.md
# rec_session_ctrl

Sequences one voice-command session on the FPGA: it detects a KEY0 press, opens a capture window of a fixed number of audio samples, and then hands the window to the ARM for inference. It waits for the ARM's result under a timeout, then latches the command for the display and motion logic. It sits between the audio sample path, the HPS handshake registers and the downstream command consumers.

## Interface
- SAMPLES_PER_WINDOW, 16000: audio samples per capture window (1 s at 16 kHz); minimum 2.
- TIMEOUT_CYCLES, 50_000_000: clk cycles allowed in INFER before the session is abandoned; minimum 2.
- DEBOUNCE_CYCLES, 1_000_000: stable-level cycles required by the debouncer; used only with DEBOUNCE_EN.
- clk  in  1  system clock.
- rstb  in  1  reset; asynchronous, active-low.
- key_n  in  1  raw KEY0, asynchronous to clk, 0 = pressed.
- sample_stb  in  1  one-cycle pulse per accepted audio sample.
- arm_done  in  1  one-cycle pulse from the ARM: inference result valid.
- arm_cmd  in  3  ARM result; sampled only when arm_done = 1.
- rec_active  out  1  high while in CAPTURE.
- infer_req  out  1  high while in INFER; the ARM reads the window while this is high.
- cmd_out  out  3  last latched command, cmd_t encoding.
- cmd_valid  out  1  one-cycle pulse when cmd_out updates.
- timeout_err  out  1  one-cycle pulse when INFER times out.
- state_out  out  2  current state, for debug.

## Operation
- cmd_t encoding: WELCOME=0, RECORDING=1, UP=2, DOWN=3, LEFT=4, RIGHT=5, STOP=6, SILENCE=7.
- Press = falling edge of the conditioned key (key_n synchronised through 2 flops, and debounced when enabled).
- States: IDLE(0), CAPTURE(1), INFER(2), HOLD(3).
- IDLE: on a press, go to CAPTURE and clear sample_cnt.
- CAPTURE:
  - Each sample_stb increments sample_cnt.
  - sample_stb while sample_cnt = SAMPLES_PER_WINDOW-1: go to INFER and clear timeout_cnt.
  - Presses are ignored.
- INFER:
  - timeout_cnt increments every cycle.
  - arm_done: latch cmd_out and pulse cmd_valid, then go to HOLD.
  - If arm_cmd is 0 or 1, cmd_out = SILENCE instead.
  - timeout_cnt = TIMEOUT_CYCLES-1 without arm_done: cmd_out = SILENCE, pulse cmd_valid and timeout_err, go to HOLD.
  - arm_done and timeout in the same cycle: arm_done wins and timeout_err stays 0.
  - Presses and sample_stb are ignored.
- HOLD: cmd_out persists. A press starts a new session (CAPTURE, sample_cnt cleared).
- arm_done outside INFER is ignored.
- sample_stb outside CAPTURE is ignored.
- Counter widths are $clog2 of their parameter. Counters never wrap, because they are cleared on state entry.

## Timing
- Reset values: state IDLE; rec_active 0; infer_req 0; cmd_out WELCOME; cmd_valid 0; timeout_err 0; both counters 0.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational path.
- key_n to detected press: 3 cycles without DEBOUNCE_EN (2 sync flops + edge register). With DEBOUNCE_EN, add DEBOUNCE_CYCLES.
- State changes take effect the cycle after the triggering event. rec_active and infer_req follow the state with no extra delay.
- cmd_valid and timeout_err are asserted in the first HOLD cycle.
- Asserting rstb mid-session aborts immediately to the reset values. The debouncer is also reset, to the released level.

## Configuration
- REC_SESSION_DEBOUNCE_EN:
  - Defined: the synchronised key passes through key_debounce. The output changes only after DEBOUNCE_CYCLES consecutive stable samples.
  - Undefined: the synchronised key feeds the edge detector directly, and DEBOUNCE_CYCLES is unused.

## Structure
- Package voice_pkg holds:
  - cmd_t (3-bit enum above), shared with state_controller consumers;
  - ctrl_state_t (2-bit);
  - localparam SAMPLE_RATE_HZ = 16000.
- Sub-module key_debounce (clk, rstb, din, dout; parameter CYCLES). Instantiated only under REC_SESSION_DEBOUNCE_EN.

## Test plan
Parameters for all scenarios: SAMPLES_PER_WINDOW=4, TIMEOUT_CYCLES=10, DEBOUNCE_CYCLES=3.
- Happy path: press, 4 sample_stb, arm_done with arm_cmd=3 → rec_active for exactly the CAPTURE span; infer_req until arm_done; cmd_out=3 with a one-cycle cmd_valid; state HOLD.
- Timeout: enter INFER, no arm_done for 10 cycles → cmd_out=7, cmd_valid=timeout_err=1 for one cycle, state HOLD.
- Collision: arm_done with arm_cmd=5 on the 10th INFER cycle → cmd_out=5, timeout_err=0.
- Ignored events: presses during CAPTURE/INFER, arm_done in IDLE, arm_cmd=1 → no state change outside spec, and the arm_cmd=1 result is latched as cmd_out=7.
- Debounce (macro defined): 2-cycle glitch on key_n → no press; a 5-cycle low → exactly one press.
- Reset mid-CAPTURE after 2 samples → all outputs at reset values. A new press requires 4 fresh samples.
